fft_bitrev_buffer: RTL

FFT_BITREV_BUFFER -- requirements
Module: fft_bitrev_buffer

---
 rtl/fft_bitrev_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fft_bitrev_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_buffer
// Brief    : Collects one N-point frame of complex samples in bit-reversed
//            order, then streams adjacent pairs to a radix-2 butterfly.
//            Optional macro FFT_BUF_SCALE_EN pre-scales inputs by 1/N.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bitrev_buffer #(
    parameter int LOG2N = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_re,
    input  logic [31:0] in_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_ia,
    output logic [31:0] out_b,
    output logic [31:0] out_ib,
    output logic        out_last
);

    localparam int N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] c_ONE       = LOG2N'(1);
    localparam logic [LOG2N-1:0] c_CNT_MAX   = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] c_LAST_PAIR = LOG2N'(N / 2 - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [31:0]      re_q [N];
    logic [31:0]      im_q [N];

    logic             w_wr_en;
    logic [LOG2N-1:0] w_wr_idx;
    logic [LOG2N-1:0] w_idx_a;
    logic [LOG2N-1:0] w_idx_b;
    logic [31:0]      w_re_st;
    logic [31:0]      w_im_st;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

`ifdef FFT_BUF_SCALE_EN
    // Divide by N up front so the log2(N) butterfly stages cannot overflow.
    assign w_re_st = $signed(in_re) >>> LOG2N;
    assign w_im_st = $signed(in_im) >>> LOG2N;
`else
    assign w_re_st = in_re;
    assign w_im_st = in_im;
`endif

    assign w_wr_idx = bitrev(cnt_q);
    // cnt < N/2 in DRAIN, so the shifted value never loses its top bit.
    assign w_idx_a  = cnt_q << 1;
    assign w_idx_b  = w_idx_a | c_ONE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_wr_en   = 1'b0;
        case (state_q)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    cnt_d   = cnt_q + c_ONE;
                    if (cnt_q == c_CNT_MAX) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_d = cnt_q + c_ONE;
                    if (cnt_q == c_LAST_PAIR) begin
                        state_d = S_FILL;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_FILL;
                cnt_d   = '0;
            end
        endcase
    end

    assign out_last = out_valid && (cnt_q == c_LAST_PAIR);
    assign out_a    = re_q[w_idx_a];
    assign out_ia   = im_q[w_idx_a];
    assign out_b    = re_q[w_idx_b];
    assign out_ib   = im_q[w_idx_b];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            for (int i = 0; i < N; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_wr_en) begin
                re_q[w_wr_idx] <= w_re_st;
                im_q[w_wr_idx] <= w_im_st;
            end
        end
    end

endmodule
`default_nettype wire
